// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and burst-length helper for the bus arbiter.
package ahb2_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  localparam int CNT_W = 5;

  // Undefined-length INCR reports 1 so it never holds the bus.
  function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb2_rr_picker.sv
// Combinational round-robin picker: first requester after i_ptr, wrapping,
// with i_ptr itself considered last.
module ahb2_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_WIDTH   = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [MID_WIDTH-1:0]   i_ptr,
  output logic [NUM_MASTERS-1:0] o_grant,
  output logic                   o_valid
);

  always_comb begin
    int idx;
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(i_ptr) + k) % NUM_MASTERS;
      if (!o_valid && i_req[MID_WIDTH'(idx)]) begin
        o_grant[MID_WIDTH'(idx)] = 1'b1;
        o_valid                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb2_arbiter.sv
// Burst-aware round-robin AHB2 arbiter with address/data owner pipeline.
// Optional master locking (hlock_i/hmastlock_o) enabled by AHB2_ARB_LOCK_EN.
module ahb2_arbiter
  import ahb2_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int MID_WIDTH      = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [NUM_MASTERS-1:0] hbusreq_i,
  output logic [NUM_MASTERS-1:0] hgrant_o,
  input  logic [1:0]             htrans_i,
  input  logic [2:0]             hburst_i,
  input  logic                   hready_i,
  input  logic [1:0]             hresp_i,
`ifdef AHB2_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] hlock_i,
  output logic                   hmastlock_o,
`endif
  output logic [MID_WIDTH-1:0]   hmaster_o,
  output logic [MID_WIDTH-1:0]   hmaster_data_o
);

  localparam logic [MID_WIDTH-1:0]   DEF_IDX   = MID_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] r_grant;
  logic [MID_WIDTH-1:0]   r_ptr;
  logic [MID_WIDTH-1:0]   r_hmaster;
  logic [MID_WIDTH-1:0]   r_hmaster_data;
  logic [CNT_W-1:0]       r_cnt;

  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_hold;
  logic [NUM_MASTERS-1:0] w_pick;
  logic                   w_pick_vld;
  logic [MID_WIDTH-1:0]   w_pick_idx;
  logic [MID_WIDTH-1:0]   w_grant_idx;

  function automatic logic [MID_WIDTH-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (v[i]) onehot_idx = MID_WIDTH'(i);
  endfunction

  ahb2_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MID_WIDTH  (MID_WIDTH)
  ) u_picker (
    .i_req  (hbusreq_i),
    .i_ptr  (r_ptr),
    .o_grant(w_pick),
    .o_valid(w_pick_vld)
  );

  assign w_pick_idx  = onehot_idx(w_pick);
  assign w_grant_idx = onehot_idx(r_grant);

  // Beats still to come after the transfer accepted on this edge.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (htrans_i == HTRANS_NONSEQ)
      w_cnt_nxt = burst_beats(hburst_i) - 5'd1;
    else if (htrans_i == HTRANS_SEQ && r_cnt != '0)
      w_cnt_nxt = r_cnt - 5'd1;
  end

`ifdef AHB2_ARB_LOCK_EN
  logic r_hmastlock;
  assign w_hold      = (w_cnt_nxt > 5'd1) || hlock_i[w_grant_idx];
  assign hmastlock_o = r_hmastlock;

  always_ff @(posedge hclk) begin
    if (!hreset_n)     r_hmastlock <= 1'b0;
    else if (hready_i) r_hmastlock <= hlock_i[w_grant_idx];
  end
`else
  assign w_hold = (w_cnt_nxt > 5'd1);
`endif

  // Grant -> address owner -> data owner, each step on an accepted transfer.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      r_grant        <= DEF_GRANT;
      r_ptr          <= DEF_IDX;
      r_hmaster      <= DEF_IDX;
      r_hmaster_data <= DEF_IDX;
      r_cnt          <= '0;
    end else if (hready_i) begin
      r_cnt          <= w_cnt_nxt;
      r_hmaster      <= w_grant_idx;
      r_hmaster_data <= r_hmaster;
      if (!w_hold) begin
        if (w_pick_vld) begin
          r_grant <= w_pick;
          r_ptr   <= w_pick_idx;
        end else begin
          r_grant <= DEF_GRANT;
        end
      end
    end else if (hresp_i != HRESP_OKAY) begin
      r_cnt <= '0;
    end
  end

  assign hgrant_o       = r_grant;
  assign hmaster_o      = r_hmaster;
  assign hmaster_data_o = r_hmaster_data;

  a_grant_onehot: assert property (@(posedge hclk) disable iff (!hreset_n) $onehot(r_grant));

endmodule

// File: tb/tb_ahb2_arbiter.sv
// Scoreboarded bench for ahb2_arbiter: directed scenarios plus randomized traffic.
module tb_ahb2_arbiter;
  import ahb2_pkg::*;

  localparam int N = 4;

  logic         hclk = 1'b0;
  logic         hreset_n;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hgrant;
  logic [1:0]   htrans;
  logic [2:0]   hburst;
  logic         hready;
  logic [1:0]   hresp;
  logic [1:0]   hmaster;
  logic [1:0]   hmaster_data;
`ifdef AHB2_ARB_LOCK_EN
  logic [N-1:0] hlock = '0;
  logic         hmastlock;
`endif

  always #5 hclk = ~hclk;

  ahb2_arbiter #(.NUM_MASTERS(N), .MID_WIDTH(2), .DEFAULT_MASTER(0)) dut (
    .hclk          (hclk),
    .hreset_n      (hreset_n),
    .hbusreq_i     (hbusreq),
    .hgrant_o      (hgrant),
    .htrans_i      (htrans),
    .hburst_i      (hburst),
    .hready_i      (hready),
    .hresp_i       (hresp),
`ifdef AHB2_ARB_LOCK_EN
    .hlock_i       (hlock),
    .hmastlock_o   (hmastlock),
`endif
    .hmaster_o     (hmaster),
    .hmaster_data_o(hmaster_data)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] am;
    logic [1:0] dm;
    logic [7:0] ph;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   phase = 0;

  // Reference model: owner indices and beats remaining as plain integers.
  int m_own, m_ptr, m_left, m_am, m_dm;
  int beat_tab[8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  task automatic model_step(input logic rn, input logic [N-1:0] req, input logic [1:0] tr,
                            input logic [2:0] bu, input logic rdy, input logic [1:0] rs);
    int left_next, best, bestd, d;
    if (!rn) begin
      m_own = 0; m_ptr = 0; m_left = 0; m_am = 0; m_dm = 0;
      return;
    end
    if (!rdy) begin
      if (rs != 2'd0) m_left = 0;
      return;
    end
    left_next = m_left;
    if (tr == 2'd2)                   left_next = beat_tab[bu] - 1;
    else if (tr == 2'd3 && m_left > 0) left_next = m_left - 1;
    m_dm = m_am;
    m_am = m_own;
    if (left_next <= 1) begin
      best = -1; bestd = N;
      for (int m = 0; m < N; m++) begin
        if (req[m]) begin
          d = (m - m_ptr - 1 + 2 * N) % N;
          if (d < bestd) begin bestd = d; best = m; end
        end
      end
      if (best >= 0) begin m_own = best; m_ptr = best; end
      else m_own = 0;
    end
    m_left = left_next;
  endtask

  // fg < 0: expectation from the model; otherwise the given constants.
  task automatic step(input logic rn, input logic [N-1:0] req, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic [1:0] rs,
                      input int fg, input int fam, input int fdm);
    exp_t e;
    @(negedge hclk);
    hreset_n = rn; hbusreq = req; htrans = tr; hburst = bu; hready = rdy; hresp = rs;
    model_step(rn, req, tr, bu, rdy, rs);
    if (fg >= 0) begin
      e.g = 4'(fg); e.am = 2'(fam); e.dm = 2'(fdm);
    end else begin
      e.g = 4'(1 << m_own); e.am = 2'(m_am); e.dm = 2'(m_dm);
    end
    e.ph = 8'(phase);
    sbq.push_back(e);
  endtask

  task automatic st(input logic [N-1:0] req, input logic [1:0] tr, input logic [2:0] bu,
                    input logic rdy, input logic [1:0] rs);
    step(1'b1, req, tr, bu, rdy, rs, -1, 0, 0);
  endtask

  task automatic chk(input string nm, input int ph, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s phase=%0d got=%0h want=%0h", nm, ph, act, exp);
    end
  endtask

  // Monitor: every edge presents a new registered output.
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("hgrant", int'(e.ph), int'(hgrant), int'(e.g));
        chk("hmaster", int'(e.ph), int'(hmaster), int'(e.am));
        chk("hmaster_data", int'(e.ph), int'(hmaster_data), int'(e.dm));
`ifdef AHB2_ARB_LOCK_EN
        chk("hmastlock", int'(e.ph), int'(hmastlock), 0);
`endif
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    logic [1:0]   tr, rs;
    logic [2:0]   bu;
    logic         rdy;
    int           wait_cyc;
    hreset_n = 1'b0; hbusreq = '0; htrans = 2'd0; hburst = 3'd0; hready = 1'b1; hresp = 2'd0;

    // Reset and idle parking on master 0
    phase = 1;
    repeat (3) step(1'b0, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0001, 0, 0);
    repeat (20) step(1'b1, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0001, 0, 0);

    // Alternating single transfers between masters 1 and 3
    phase = 2;
    step(1'b1, 4'b1010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b0010, 0, 0);
    step(1'b1, 4'b1010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b1000, 1, 0);
    step(1'b1, 4'b1010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b0010, 3, 1);
    step(1'b1, 4'b1010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b1000, 1, 3);
    step(1'b1, 4'b1010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b0010, 3, 1);

    // INCR8 from master 2 with master 0 waiting
    phase = 3;
    step(1'b0, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0001, 0, 0);
    st(4'b0100, 2'd0, 3'd0, 1'b1, 2'd0);
    st(4'b0100, 2'd0, 3'd0, 1'b1, 2'd0);
    step(1'b1, 4'b0101, 2'd2, 3'd5, 1'b1, 2'd0, 4'b0100, 2, 2);
    for (int b = 2; b <= 6; b++) st(4'b0101, 2'd3, 3'd5, 1'b1, 2'd0);
    step(1'b1, 4'b0101, 2'd3, 3'd5, 1'b1, 2'd0, 4'b0001, 2, 2);
    step(1'b1, 4'b0001, 2'd3, 3'd5, 1'b1, 2'd0, 4'b0001, 0, 2);
    step(1'b1, 4'b0001, 2'd2, 3'd0, 1'b1, 2'd0, 4'b0001, 0, 0);

    // INCR4 with wait states on beat 2
    phase = 4;
    st(4'b0010, 2'd0, 3'd0, 1'b1, 2'd0);
    st(4'b0010, 2'd0, 3'd0, 1'b1, 2'd0);
    st(4'b1010, 2'd2, 3'd3, 1'b1, 2'd0);
    st(4'b1010, 2'd3, 3'd3, 1'b1, 2'd0);
    repeat (3) st(4'b1010, 2'd3, 3'd3, 1'b0, 2'd0);
    st(4'b1010, 2'd3, 3'd3, 1'b1, 2'd0);
    st(4'b1000, 2'd3, 3'd3, 1'b1, 2'd0);

    // WRAP16 terminated by an ERROR response
    phase = 5;
    st(4'b1000, 2'd0, 3'd0, 1'b1, 2'd0);
    st(4'b1001, 2'd2, 3'd6, 1'b1, 2'd0);
    st(4'b1001, 2'd3, 3'd6, 1'b1, 2'd0);
    st(4'b1001, 2'd3, 3'd6, 1'b0, 2'd1);
    st(4'b1001, 2'd0, 3'd6, 1'b1, 2'd1);
    repeat (3) st(4'b0001, 2'd0, 3'd0, 1'b1, 2'd0);

    // Randomized traffic with wait states, error responses and resets
    phase = 6;
    for (int c = 0; c < 3000; c++) begin
      rq  = 4'($urandom_range(0, 15));
      bu  = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      rs  = (!rdy && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (m_left > 0)
        case ($urandom_range(0, 9))
          0: tr = 2'd2;
          1: tr = 2'd1;
          2: tr = 2'd0;
          default: tr = 2'd3;
        endcase
      else
        tr = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0)
        step(1'b0, rq, tr, bu, rdy, rs, -1, 0, 0);
      else
        st(rq, tr, bu, rdy, rs);
    end

    wait_cyc = 0;
    while (sbq.size() > 0 && wait_cyc < 100) begin
      @(posedge hclk);
      wait_cyc++;
    end
    #2;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
